uart_rx_mmio: RTL and testbench

// Console-input half of the UART path: deserialises an 8N1 serial line (rxd) into bytes,

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_rx_mmio.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, MMIO addresses and status word layout.
// Used by the receive MMIO block and the UART byte sink.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [31:0] RX_DATA_ADDR_DEF = 32'hFFFF_FFF8;
  localparam logic [31:0] RX_STAT_ADDR_DEF = 32'hFFFF_FFF4;

  // Status word bit positions
  localparam int unsigned STAT_NONEMPTY_BIT = 0;
  localparam int unsigned STAT_OVERRUN_BIT  = 1;
  localparam int unsigned STAT_FRAMEERR_BIT = 2;
  localparam int unsigned STAT_COUNT_LSB    = 8;
  localparam int unsigned STAT_COUNT_W      = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with separate occupancy counter.
// Ports: clk, rst (sync, active-high), push/wdata, pop, rdata (head, combinational),
//        full, empty, count (0..DEPTH).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  // Pop of an empty FIFO is ignored; a pop frees room for a same-cycle push when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, contents irrelevant while empty so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with receive FIFO, exposed as memory-mapped data/status words.
// Ports: clk, rst (sync, active-high), rxd (async serial in, idle high),
//        addr/rdEn (dmem read side), rData (combinational read data, 0 on miss),
//        hit (address decode for the external rdata mux), rxIrq (FIFO non-empty, registered).
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] RX_DATA_ADDR = RX_DATA_ADDR_DEF,
  parameter logic [31:0] RX_STAT_ADDR = RX_STAT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [31:0] addr,
  input  logic        rdEn,
  output logic [31:0] rData,
  output logic        hit,
  output logic        rxIrq
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  rx_state_t     state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          brk_q, brk_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_irq_q, rx_irq_d;
  logic          sync1_q, rxs_q;

  logic          push_c, frame_err_set_c;
  logic          data_sel_c, stat_sel_c, pop_c, stat_rd_c;
  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   stat_word_c;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .wdata (shift_q),
    .pop   (pop_c),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Address decode and read strobes
  assign data_sel_c = (addr == RX_DATA_ADDR);
  assign stat_sel_c = (addr == RX_STAT_ADDR);
  assign hit        = data_sel_c || stat_sel_c;
  assign pop_c      = rdEn && data_sel_c && !fifo_empty;
  assign stat_rd_c  = rdEn && stat_sel_c;
  assign rxIrq      = rx_irq_q;

  // Receiver FSM next state, bit timing and error flags
  always_comb begin
    state_d         = state_q;
    tick_d          = tick_q + TW'(1);
    bit_d           = bit_q;
    shift_d         = shift_q;
    brk_d           = brk_q;
    push_c          = 1'b0;
    frame_err_set_c = 1'b0;

    case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        // After a framing error the line must go high before a new start is accepted.
        if (rxs_q) brk_d = 1'b0;
        if (!rxs_q && !brk_q) state_d = START;
      end
      START: begin
        if (tick_q == HALF_M1) begin
          tick_d  = '0;
          state_d = rxs_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_q == FULL_M1) begin
          tick_d  = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick_q == FULL_M1) begin
          tick_d  = '0;
          state_d = IDLE;
          if (rxs_q) begin
            push_c = 1'b1;
          end else begin
            frame_err_set_c = 1'b1;
            brk_d           = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A same-cycle set takes priority over the status-read clear.
    overrun_d   = (push_c && fifo_full && !pop_c) || (overrun_q && !stat_rd_c);
    frame_err_d = frame_err_set_c || (frame_err_q && !stat_rd_c);
    rx_irq_d    = !fifo_empty;
  end

  // State registers and rxd synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      brk_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_irq_q    <= 1'b0;
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      brk_q       <= brk_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rx_irq_q    <= rx_irq_d;
      sync1_q     <= rxd;
      rxs_q       <= sync1_q;
    end
  end

  // Read data mux
  always_comb begin
    stat_word_c = '0;
    stat_word_c[STAT_NONEMPTY_BIT] = !fifo_empty;
    stat_word_c[STAT_OVERRUN_BIT]  = overrun_q;
    stat_word_c[STAT_FRAMEERR_BIT] = frame_err_q;
    stat_word_c[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);

    rData = '0;
    if (data_sel_c) begin
      if (!fifo_empty) rData = {24'b0, fifo_head};
    end else if (stat_sel_c) begin
      rData = stat_word_c;
    end
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed testbench for uart_rx_mmio (CLKS_PER_BIT=16, FIFO_DEPTH=4).
module tb_uart_rx_mmio;

  localparam logic [31:0] DATA_A = 32'hFFFF_FFF8;
  localparam logic [31:0] STAT_A = 32'hFFFF_FFF4;
  localparam logic [31:0] MISS_A = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic [31:0] addr;
  logic        rdEn;
  logic [31:0] rData;
  logic        hit;
  logic        rxIrq;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] popped;

  always #5 clk = ~clk;

  uart_rx_mmio #(
    .CLKS_PER_BIT (16),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .addr  (addr),
    .rdEn  (rdEn),
    .rData (rData),
    .hit   (hit),
    .rxIrq (rxIrq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle read strobe; rData is checked mid-cycle, the pop/clear lands on the next edge.
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    addr = a;
    rdEn = 1'b1;
    #1;
    chk(tag, rData, exp);
    @(posedge clk);
    #1;
    rdEn = 1'b0;
    addr = '0;
  endtask

  // Drive one 8N1 frame. Edge E0 is the edge just before the start bit; the stop sample
  // (and push) falls on E155, so a read strobe raised after E154 pops on that same edge.
  // rst_bit >= 0 aborts with a reset pulse inside that bit slot (1 = data bit 0).
  task automatic send(input logic [7:0] b, input logic stop_v, input logic pop_stop,
                      input int rst_bit);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    @(posedge clk);
    #1;
    for (int n = 0; n < 10; n++) begin
      for (int c = 0; c < 16; c++) begin
        if (c == 0) rxd = fr[n];
        if (pop_stop && n == 9 && c == 10) begin
          addr = DATA_A;
          rdEn = 1'b1;
          #1;
          popped = rData;
        end
        if (pop_stop && n == 9 && c == 11) begin
          rdEn = 1'b0;
          addr = '0;
        end
        if (n == rst_bit && c == 4) begin
          rst = 1'b1;
          rxd = 1'b1;
          @(posedge clk);
          #1;
          @(posedge clk);
          #1;
          rst = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
      end
    end
    rxd = 1'b1;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog cycle budget expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    rxd  = 1'b1;
    rdEn = 1'b0;
    addr = '0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Reset state and address decode
    chk("reset_irq", {31'b0, rxIrq}, 32'h0);
    @(negedge clk);
    addr = STAT_A;
    #1;
    chk("hit_stat", {31'b0, hit}, 32'h1);
    chk("reset_stat", rData, 32'h0);
    addr = DATA_A;
    #1;
    chk("hit_data", {31'b0, hit}, 32'h1);
    addr = MISS_A;
    #1;
    chk("hit_miss", {31'b0, hit}, 32'h0);
    addr = '0;
    rd(DATA_A, 32'h0, "empty_data_rd");
    rd(STAT_A, 32'h0, "empty_no_side_effect");

    // Single byte
    send(8'hA5, 1'b1, 1'b0, -1);
    idle(20);
    chk("irq_a5", {31'b0, rxIrq}, 32'h1);
    rd(STAT_A, 32'h0000_0101, "stat_a5");
    rd(DATA_A, 32'h0000_00A5, "data_a5");
    rd(STAT_A, 32'h0, "stat_after_a5");
    idle(2);
    chk("irq_clear", {31'b0, rxIrq}, 32'h0);

    // Overrun: five bytes into a four-deep FIFO
    send(8'h00, 1'b1, 1'b0, -1);
    idle(20);
    send(8'hFF, 1'b1, 1'b0, -1);
    idle(20);
    send(8'h55, 1'b1, 1'b0, -1);
    idle(20);
    send(8'h81, 1'b1, 1'b0, -1);
    idle(20);
    send(8'h3C, 1'b1, 1'b0, -1);
    idle(20);
    rd(STAT_A, 32'h0000_0403, "stat_overrun");
    rd(DATA_A, 32'h0000_0000, "ovr_d0");
    rd(DATA_A, 32'h0000_00FF, "ovr_d1");
    rd(DATA_A, 32'h0000_0055, "ovr_d2");
    rd(DATA_A, 32'h0000_0081, "ovr_d3");
    rd(STAT_A, 32'h0, "stat_after_ovr");

    // Framing error
    send(8'h42, 1'b0, 1'b0, -1);
    idle(20);
    rd(STAT_A, 32'h0000_0004, "stat_frame_err");
    rd(STAT_A, 32'h0, "stat_frame_clr");

    // Short low glitch on an idle line
    @(posedge clk);
    #1;
    rxd = 1'b0;
    idle(5);
    rxd = 1'b1;
    idle(30);
    rd(STAT_A, 32'h0, "stat_glitch");
    rd(DATA_A, 32'h0, "data_glitch");

    // Full FIFO with a pop on the same edge as the stop-bit push
    send(8'h11, 1'b1, 1'b0, -1);
    idle(20);
    send(8'h22, 1'b1, 1'b0, -1);
    idle(20);
    send(8'h33, 1'b1, 1'b0, -1);
    idle(20);
    send(8'h44, 1'b1, 1'b0, -1);
    idle(20);
    rd(STAT_A, 32'h0000_0401, "stat_full");
    send(8'h55, 1'b1, 1'b1, -1);
    idle(20);
    chk("popped_at_push", popped, 32'h0000_0011);
    rd(STAT_A, 32'h0000_0401, "stat_push_pop");
    rd(DATA_A, 32'h0000_0022, "pp_d0");
    rd(DATA_A, 32'h0000_0033, "pp_d1");
    rd(DATA_A, 32'h0000_0044, "pp_d2");
    rd(DATA_A, 32'h0000_0055, "pp_d3");
    rd(STAT_A, 32'h0, "stat_after_pp");

    // Reset mid-frame with two bytes buffered
    send(8'h01, 1'b1, 1'b0, -1);
    idle(20);
    send(8'h02, 1'b1, 1'b0, -1);
    idle(20);
    rd(STAT_A, 32'h0000_0201, "stat_two");
    send(8'h77, 1'b1, 1'b0, 4);
    idle(20);
    rd(STAT_A, 32'h0, "stat_after_rst");
    chk("irq_after_rst", {31'b0, rxIrq}, 32'h0);
    send(8'h19, 1'b1, 1'b0, -1);
    idle(20);
    rd(STAT_A, 32'h0000_0101, "stat_19");
    rd(DATA_A, 32'h0000_0019, "data_19");
    rd(STAT_A, 32'h0, "stat_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
